// File: rtl/ysyx_23060208_rd_arbiter_pkg.sv
// Shared encodings for the data-SRAM read-port arbiter: FSM states and one-hot owner codes.
package ysyx_23060208_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    RDARB_IDLE = 2'd0,
    RDARB_AR   = 2'd1,
    RDARB_R    = 2'd2,
    RDARB_GAP  = 2'd3
  } rdarb_state_e;

  localparam logic [1:0] RDARB_M0 = 2'b01;
  localparam logic [1:0] RDARB_M1 = 2'b10;

endpackage

// File: rtl/ysyx_23060208_rd_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: one-hot grant, the master not granted last wins a tie.
module ysyx_23060208_rd_arbiter_rr_pick2
  import ysyx_23060208_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? RDARB_M0 : RDARB_M1;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Round-robin share of one AXI4-lite read port between IFU (M0) and EXU (M1), one read in flight.
// One arbitration cycle before AR; a stalled slave or owner rready stalls only the owner, the other master waits.
module ysyx_23060208_rd_arbiter
  import ysyx_23060208_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDLE_GAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,

  input  logic [DATA_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,

  output logic [DATA_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,

  output logic [1:0]            owner
);

  rdarb_state_e state_q, state_d;
  logic [1:0]   owner_q, owner_d;
  logic         last_q, last_d;
  logic [1:0]   grant;

  logic own0, own1, in_ar, in_r;

  ysyx_23060208_rd_arbiter_rr_pick2 u_pick (
    .req   ({m1_arvalid, m0_arvalid}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      RDARB_IDLE: begin
        if (|grant) begin
          owner_d = grant;
          last_d  = grant[1];
          state_d = RDARB_AR;
        end
      end
      RDARB_AR: begin
        if (s_arvalid && s_arready) state_d = RDARB_R;
      end
      RDARB_R: begin
        if (s_rvalid && s_rready) begin
          owner_d = 2'b00;
          state_d = (IDLE_GAP == 1) ? RDARB_GAP : RDARB_IDLE;
        end
      end
      RDARB_GAP: state_d = RDARB_IDLE;
      default:   state_d = RDARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RDARB_IDLE;
      owner_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Every output is qualified by owner, so nothing leaks out while no master owns the port.
  assign own0  = owner_q[0];
  assign own1  = owner_q[1];
  assign in_ar = (state_q == RDARB_AR);
  assign in_r  = (state_q == RDARB_R);

  assign s_araddr  = own1 ? m1_araddr : (own0 ? m0_araddr : '0);
  assign s_arvalid = in_ar & ((own0 & m0_arvalid) | (own1 & m1_arvalid));
  assign s_rready  = in_r  & ((own0 & m0_rready)  | (own1 & m1_rready));

  assign m0_arready = in_ar & own0 & s_arready;
  assign m1_arready = in_ar & own1 & s_arready;
  assign m0_rvalid  = in_r  & own0 & s_rvalid;
  assign m1_rvalid  = in_r  & own1 & s_rvalid;
  assign m0_rdata   = own0 ? s_rdata : '0;
  assign m1_rdata   = own1 ? s_rdata : '0;
  assign m0_rresp   = own0 ? s_rresp : 2'b00;
  assign m1_rresp   = own1 ? s_rresp : 2'b00;

  assign owner = owner_q;

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed bench for the read-port arbiter: inputs driven on the falling edge, outputs checked 1ns later.
module tb_ysyx_23060208_rd_arbiter;
  import ysyx_23060208_rd_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, s_araddr, s_rdata, m0_rdata, m1_rdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  m0_rresp, m1_rresp, s_rresp, owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060208_rd_arbiter #(.DATA_WIDTH(32), .IDLE_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .owner(owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic own_arready(input logic [1:0] o);
    return o[1] ? m1_arready : m0_arready;
  endfunction
  function automatic logic oth_arready(input logic [1:0] o);
    return o[1] ? m0_arready : m1_arready;
  endfunction
  function automatic logic own_rvalid(input logic [1:0] o);
    return o[1] ? m1_rvalid : m0_rvalid;
  endfunction
  function automatic logic oth_rvalid(input logic [1:0] o);
    return o[1] ? m0_rvalid : m1_rvalid;
  endfunction
  function automatic logic [31:0] own_rdata(input logic [1:0] o);
    return o[1] ? m1_rdata : m0_rdata;
  endfunction
  function automatic logic [1:0] own_rresp(input logic [1:0] o);
    return o[1] ? m1_rresp : m0_rresp;
  endfunction

  // The non-owner keeps rready high so a wrongly muxed s_rready shows up.
  task automatic set_rready(input logic [1:0] o, input logic v);
    if (o[1]) begin
      m1_rready = v;
      m0_rready = 1'b1;
    end else begin
      m0_rready = v;
      m1_rready = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    step(); #1;
    check("idle_owner", 32'(owner), 32'd0);
    check("idle_arvalid", 32'(s_arvalid), 32'd0);
  endtask

  // One read from the cycle after arbitration through GAP; returns at the GAP falling edge.
  task automatic txn(input logic [1:0] o, input logic [31:0] addr, input int ar_wait,
                     input int r_wait, input int bp, input logic [31:0] data, input logic [1:0] resp);
    step(); s_arready = 1'b0; #1;
    check("grant_owner", 32'(owner), 32'(o));
    check("ar_addr", s_araddr, addr);
    check("ar_valid", 32'(s_arvalid), 32'd1);
    for (int i = 0; i < ar_wait; i++) begin
      check("ar_wait_rdy", 32'({own_arready(o), oth_arready(o)}), 32'd0);
      check("ar_wait_owner", 32'(owner), 32'(o));
      step(); #1;
    end
    s_arready = 1'b1; #1;
    check("ar_hs_rdy", 32'({own_arready(o), oth_arready(o)}), 32'h2);
    step(); s_arready = 1'b0; s_rvalid = 1'b0; set_rready(o, 1'b1); #1;
    for (int i = 0; i < r_wait; i++) begin
      check("r_wait_vld", 32'({own_rvalid(o), oth_rvalid(o)}), 32'd0);
      check("r_wait_oth_ar", 32'(oth_arready(o)), 32'd0);
      step(); #1;
    end
    for (int i = 0; i < bp; i++) begin
      set_rready(o, 1'b0); s_rvalid = 1'b1; s_rdata = data; s_rresp = resp; #1;
      check("bp_srready", 32'(s_rready), 32'd0);
      check("bp_owner", 32'(owner), 32'(o));
      check("bp_rvalid", 32'(own_rvalid(o)), 32'd1);
      step(); #1;
    end
    set_rready(o, 1'b1); s_rvalid = 1'b1; s_rdata = data; s_rresp = resp; #1;
    check("r_data", own_rdata(o), data);
    check("r_resp", 32'(own_rresp(o)), 32'(resp));
    check("r_vld", 32'({own_rvalid(o), oth_rvalid(o), s_rready}), 32'h5);
    step(); s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; #1;
    check("gap_owner", 32'(owner), 32'd0);
    check("gap_outs", 32'({m0_rvalid, m1_rvalid, s_arvalid, s_rready}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    m0_araddr = 32'h1000; m1_araddr = 32'h2000;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;

    // Reset held with both masters requesting; M0 must win the first tie.
    repeat (3) begin
      step(); #1;
      check("rst_outs", 32'({owner, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}), 32'd0);
    end
    rst = 1'b1; #1;
    check("rel_owner", 32'(owner), 32'd0);
    txn(RDARB_M0, 32'h1000, 0, 0, 0, 32'h11, 2'b00);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // Lone EXU load, data two cycles after the address handshake.
    m1_araddr = 32'h8000_0010; m1_arvalid = 1'b1;
    idle_cycle();
    txn(RDARB_M1, 32'h8000_0010, 0, 2, 0, 32'hDEAD_BEEF, 2'b00);
    m1_arvalid = 1'b0;

    // Both masters hammering: strict alternation starting from M0.
    m0_araddr = 32'h100; m1_araddr = 32'h200;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    idle_cycle(); txn(RDARB_M0, 32'h100, 0, 0, 0, 32'hA0, 2'b00);
    idle_cycle(); txn(RDARB_M1, 32'h200, 0, 0, 0, 32'hA1, 2'b00);
    idle_cycle(); txn(RDARB_M0, 32'h100, 0, 0, 0, 32'hA2, 2'b00);
    idle_cycle(); txn(RDARB_M1, 32'h200, 0, 0, 0, 32'hA3, 2'b10);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // Slow slave: M0 keeps the port while M1 waits, then M1 is served.
    m0_araddr = 32'h300; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    idle_cycle(); txn(RDARB_M0, 32'h300, 5, 7, 0, 32'hCAFE_F00D, 2'b01);
    m0_arvalid = 1'b0;
    idle_cycle(); txn(RDARB_M1, 32'h200, 0, 0, 0, 32'h55, 2'b00);
    m1_arvalid = 1'b0;

    // Owner holds rready low for three cycles with data waiting.
    m0_araddr = 32'h400; m0_arvalid = 1'b1;
    idle_cycle(); txn(RDARB_M0, 32'h400, 0, 0, 3, 32'h1234_5678, 2'b00);
    m0_arvalid = 1'b0;

    // Reset during R; last returns to M1 so M0 must win the next tie.
    m0_araddr = 32'h500; m0_arvalid = 1'b1;
    idle_cycle();
    step(); #1;
    check("t6_owner", 32'(owner), 32'(RDARB_M0));
    s_arready = 1'b1;
    step(); s_arready = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b1; #1;
    check("t6_in_r", 32'({owner, s_rready}), 32'h3);
    rst = 1'b0; m1_arvalid = 1'b1;
    step(); #1;
    check("t6_rst_outs", 32'({owner, m0_rvalid, m1_rvalid, s_rready, s_arvalid}), 32'd0);
    rst = 1'b1; #1;
    check("t6_rel_owner", 32'(owner), 32'd0);
    txn(RDARB_M0, 32'h500, 0, 0, 0, 32'h66, 2'b00);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
